// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: pipeline status in, stage enables/flushes/redirect out.
// The master side drives pipeline status; the slave side (hazard_ctrl) drives pipeline control.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             ihit;
   logic             dhit;
   logic             mem_dreq;
   logic             mem_halt;
   logic             br_taken;
   logic [31:0]      br_target;
   logic [4:0]       id_rsel1;
   logic [4:0]       id_rsel2;
   logic [4:0]       ex_wsel;
   logic             ex_wen;
   logic             ex_memread;

   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;
   logic             memwb_flush;
   logic             pc_redirect;
   logic [31:0]      redirect_addr;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] redir_cnt;

   modport master (
      output ihit, dhit, mem_dreq, mem_halt, br_taken, br_target,
             id_rsel1, id_rsel2, ex_wsel, ex_wen, ex_memread,
      input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush,
             pc_redirect, redirect_addr, halted, stall_cnt, redir_cnt
   );

   modport slave (
      input  ihit, dhit, mem_dreq, mem_halt, br_taken, br_target,
             id_rsel1, id_rsel2, ex_wsel, ex_wen, ex_memread,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush,
             pc_redirect, redirect_addr, halted, stall_cnt, redir_cnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables/flushes and PC redirect, combinational from state and inputs.
// Holds a branch target across an outstanding fetch (FPEND) and halts stickily until reset.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input logic         CLK,
   input logic         nRST,
   hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FPEND = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        tgt_q, tgt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]   redir_cnt_q, redir_cnt_d;

   logic               dstall;
   logic               luse;
   logic               pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic               ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic               pc_redirect;
   logic [31:0]        redirect_addr;
   logic               stall_inc;

   assign dstall = bus.mem_dreq & ~bus.dhit;
   assign luse   = bus.ex_memread & bus.ex_wen & (bus.ex_wsel != 5'd0) &
                   ((bus.ex_wsel == bus.id_rsel1) | (bus.ex_wsel == bus.id_rsel2));

   always_comb begin
      state_d       = state_q;
      tgt_d         = tgt_q;
      pc_en         = 1'b1;
      ifid_en       = 1'b1;
      idex_en       = 1'b1;
      exmem_en      = 1'b1;
      memwb_en      = 1'b1;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      exmem_flush   = 1'b0;
      memwb_flush   = 1'b0;
      pc_redirect   = 1'b0;
      redirect_addr = tgt_q;

      if (state_q == HALT || bus.mem_halt) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
         state_d  = HALT;
      end else if (dstall) begin
         // Freeze everything upstream of MEM; WB receives a bubble while MEM waits.
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_flush = 1'b1;
      end else if (bus.br_taken) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         if (bus.ihit) begin
            pc_redirect   = 1'b1;
            redirect_addr = bus.br_target;
            state_d       = RUN;
         end else begin
            // Fetch still in flight: park the target until it lands.
            pc_en   = 1'b0;
            tgt_d   = bus.br_target;
            state_d = FPEND;
         end
      end else if (state_q == FPEND) begin
         ifid_flush = 1'b1;
         if (bus.ihit) begin
            pc_redirect = 1'b1;
            state_d     = RUN;
         end else begin
            pc_en = 1'b0;
         end
      end else if (luse) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (!bus.ihit) begin
         pc_en      = 1'b0;
         ifid_flush = 1'b1;
      end

      // Control outputs are quiet while reset is held.
      if (!nRST) begin
         pc_en         = 1'b0;
         ifid_en       = 1'b0;
         idex_en       = 1'b0;
         exmem_en      = 1'b0;
         memwb_en      = 1'b0;
         ifid_flush    = 1'b0;
         idex_flush    = 1'b0;
         exmem_flush   = 1'b0;
         memwb_flush   = 1'b0;
         pc_redirect   = 1'b0;
         redirect_addr = 32'd0;
      end
   end

   assign stall_inc = ~pc_en & (state_q != HALT) & ~bus.mem_halt;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      redir_cnt_d = redir_cnt_q;
      if (stall_inc && stall_cnt_q != {CNT_W{1'b1}})
         stall_cnt_d = stall_cnt_q + 1'b1;
      if (pc_redirect && redir_cnt_q != {CNT_W{1'b1}})
         redir_cnt_d = redir_cnt_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= RUN;
         tgt_q       <= 32'd0;
         stall_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         tgt_q       <= tgt_d;
         stall_cnt_q <= stall_cnt_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign bus.pc_en         = pc_en;
   assign bus.ifid_en       = ifid_en;
   assign bus.idex_en       = idex_en;
   assign bus.exmem_en      = exmem_en;
   assign bus.memwb_en      = memwb_en;
   assign bus.ifid_flush    = ifid_flush;
   assign bus.idex_flush    = idex_flush;
   assign bus.exmem_flush   = exmem_flush;
   assign bus.memwb_flush   = memwb_flush;
   assign bus.pc_redirect   = pc_redirect;
   assign bus.redirect_addr = redirect_addr;
   assign bus.halted        = nRST & (state_q == HALT);
   assign bus.stall_cnt     = stall_cnt_q;
   assign bus.redir_cnt     = redir_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: driver queues expected outputs, negedge monitor checks them.
module tb_hazard_ctrl;

   localparam int CNT_W = 16;

   typedef struct packed {
      logic        nrst, ihit, dhit, mem_dreq, mem_halt, br_taken;
      logic [31:0] br_target;
      logic [4:0]  rsel1, rsel2, wsel;
      logic        wen, memread;
   } stim_t;

   typedef struct packed {
      logic [4:0]  en;      // pc, ifid, idex, exmem, memwb
      logic [3:0]  fl;      // ifid, idex, exmem, memwb
      logic        redir;
      logic [31:0] raddr;
      logic        halted;
      logic        chk_cnt;
      logic [15:0] stall;
      logic [15:0] rcnt;
   } exp_t;

   logic  CLK = 1'b0;
   logic  nRST;
   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;
   stim_t s;

   always #5 CLK = ~CLK;

   hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();
   hazard_ctrl #(.CNT_W(CNT_W)) dut (.CLK(CLK), .nRST(nRST), .bus(bus.slave));

   function automatic stim_t idle();
      stim_t t;
      t      = '0;
      t.nrst = 1'b1;
      t.ihit = 1'b1;
      return t;
   endfunction

   function automatic exp_t ex(logic [4:0] en, logic [3:0] fl, logic redir, logic [31:0] raddr,
                               logic halted);
      exp_t e;
      e        = '0;
      e.en     = en;
      e.fl     = fl;
      e.redir  = redir;
      e.raddr  = raddr;
      e.halted = halted;
      return e;
   endfunction

   function automatic exp_t exc(logic [4:0] en, logic [3:0] fl, logic redir, logic [31:0] raddr,
                                logic halted, logic [15:0] stall, logic [15:0] rcnt);
      exp_t e;
      e         = ex(en, fl, redir, raddr, halted);
      e.chk_cnt = 1'b1;
      e.stall   = stall;
      e.rcnt    = rcnt;
      return e;
   endfunction

   task automatic apply(input stim_t t);
      nRST           = t.nrst;
      bus.ihit       = t.ihit;
      bus.dhit       = t.dhit;
      bus.mem_dreq   = t.mem_dreq;
      bus.mem_halt   = t.mem_halt;
      bus.br_taken   = t.br_taken;
      bus.br_target  = t.br_target;
      bus.id_rsel1   = t.rsel1;
      bus.id_rsel2   = t.rsel2;
      bus.ex_wsel    = t.wsel;
      bus.ex_wen     = t.wen;
      bus.ex_memread = t.memread;
   endtask

   task automatic drive(input stim_t t);
      @(posedge CLK);
      #1;
      apply(t);
   endtask

   task automatic step(input stim_t t, input exp_t e, input string nm);
      drive(t);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   always @(negedge CLK) begin : monitor
      exp_t        e;
      string       nm;
      logic [4:0]  a_en;
      logic [3:0]  a_fl;
      if (exp_q.size() > 0) begin
         e    = exp_q.pop_front();
         nm   = name_q.pop_front();
         a_en = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en};
         a_fl = {bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};
         checks++;
         if (a_en !== e.en || a_fl !== e.fl || bus.pc_redirect !== e.redir ||
             bus.redirect_addr !== e.raddr || bus.halted !== e.halted) begin
            errors++;
            $display("FAIL %s ctrl: got en=%b fl=%b redir=%b raddr=%h halted=%b, expected en=%b fl=%b redir=%b raddr=%h halted=%b",
                     nm, a_en, a_fl, bus.pc_redirect, bus.redirect_addr, bus.halted,
                     e.en, e.fl, e.redir, e.raddr, e.halted);
         end
         if (e.chk_cnt) begin
            checks++;
            if (bus.stall_cnt !== e.stall || bus.redir_cnt !== e.rcnt) begin
               errors++;
               $display("FAIL %s counters: got stall=%0d redir=%0d, expected stall=%0d redir=%0d",
                        nm, bus.stall_cnt, bus.redir_cnt, e.stall, e.rcnt);
            end
         end
      end
   end

   initial begin
      s = idle(); s.nrst = 1'b0; s.ihit = 1'b0; s.mem_dreq = 1'b1;
      apply(s);
      step(s, exc(5'b00000, 4'b0000, 0, 32'h0, 0, 0, 0), "reset_a");
      s.br_taken = 1'b1; s.br_target = 32'hDEAD_BEEF; s.ihit = 1'b1;
      step(s, exc(5'b00000, 4'b0000, 0, 32'h0, 0, 0, 0), "reset_b");

      s = idle();
      step(s, exc(5'b11111, 4'b0000, 0, 32'h0, 0, 0, 0), "idle");

      // load-use on rs1, then on rs2, plus non-hazard variants
      s = idle(); s.memread = 1; s.wen = 1; s.wsel = 5'd3; s.rsel1 = 5'd3;
      step(s, exc(5'b00111, 4'b0100, 0, 32'h0, 0, 0, 0), "luse_r3");
      s = idle();
      step(s, exc(5'b11111, 4'b0000, 0, 32'h0, 0, 1, 0), "after_luse");
      s = idle(); s.memread = 1; s.wen = 1; s.wsel = 5'd0; s.rsel1 = 5'd0;
      step(s, exc(5'b11111, 4'b0000, 0, 32'h0, 0, 1, 0), "luse_r0");
      s = idle(); s.memread = 0; s.wen = 1; s.wsel = 5'd7; s.rsel2 = 5'd7;
      step(s, ex(5'b11111, 4'b0000, 0, 32'h0, 0), "alu_dep");
      s.memread = 1;
      step(s, exc(5'b00111, 4'b0100, 0, 32'h0, 0, 1, 0), "luse_rs2");

      // data stall: three frozen cycles, then completes
      s = idle(); s.mem_dreq = 1; s.dhit = 0;
      for (int i = 0; i < 3; i++)
         step(s, ex(5'b00001, 4'b0001, 0, 32'h0, 0), "dstall");
      s.dhit = 1;
      step(s, exc(5'b11111, 4'b0000, 0, 32'h0, 0, 5, 0), "dstall_done");
      s = idle(); s.ihit = 0;
      step(s, ex(5'b01111, 4'b1000, 0, 32'h0, 0), "imiss");

      // branch with outstanding fetch
      s = idle(); s.br_taken = 1; s.br_target = 32'h40; s.ihit = 0;
      step(s, exc(5'b01111, 4'b1110, 0, 32'h0, 0, 6, 0), "br_miss");
      s = idle(); s.ihit = 0;
      step(s, ex(5'b01111, 4'b1000, 0, 32'h40, 0), "fpend_wait");
      s.ihit = 1;
      step(s, ex(5'b11111, 4'b1000, 1, 32'h40, 0), "fpend_done");
      s = idle();
      step(s, exc(5'b11111, 4'b0000, 0, 32'h40, 0, 8, 1), "after_fpend");

      // branch with fetch done: immediate redirect, latched target untouched
      s = idle(); s.br_taken = 1; s.br_target = 32'h100;
      step(s, ex(5'b11111, 4'b1110, 1, 32'h100, 0), "br_hit");
      s = idle();
      step(s, exc(5'b11111, 4'b0000, 0, 32'h40, 0, 8, 2), "after_br_hit");

      // branch overwrites a pending target; dstall in FPEND holds it
      s = idle(); s.br_taken = 1; s.br_target = 32'h80; s.ihit = 0;
      step(s, ex(5'b01111, 4'b1110, 0, 32'h40, 0), "br_miss2");
      s.br_target = 32'hC0;
      step(s, ex(5'b01111, 4'b1110, 0, 32'h80, 0), "br_in_fpend");
      s = idle(); s.mem_dreq = 1; s.dhit = 0; s.ihit = 1;
      step(s, ex(5'b00001, 4'b0001, 0, 32'hC0, 0), "dstall_fpend");
      s = idle();
      step(s, ex(5'b11111, 4'b1000, 1, 32'hC0, 0), "fpend_done2");
      step(s, exc(5'b11111, 4'b0000, 0, 32'hC0, 0, 11, 3), "after_fpend2");

      // reset mid-FPEND discards the pending redirect
      s = idle(); s.br_taken = 1; s.br_target = 32'h200; s.ihit = 0;
      step(s, ex(5'b01111, 4'b1110, 0, 32'hC0, 0), "br_miss3");
      s = idle(); s.nrst = 0; s.ihit = 1;
      step(s, exc(5'b00000, 4'b0000, 0, 32'h0, 0, 0, 0), "rst_fpend");
      s = idle();
      step(s, exc(5'b11111, 4'b0000, 0, 32'h0, 0, 0, 0), "post_rst_run");

      // halt beats dstall and load-use, then sticks
      s = idle(); s.mem_halt = 1; s.mem_dreq = 1; s.dhit = 0;
      s.memread = 1; s.wen = 1; s.wsel = 5'd3; s.rsel1 = 5'd3;
      step(s, exc(5'b00000, 4'b0000, 0, 32'h0, 0, 0, 0), "halt_prio");
      s = idle(); s.br_taken = 1; s.br_target = 32'h300; s.ihit = 0;
      step(s, ex(5'b00000, 4'b0000, 0, 32'h0, 1), "halted_br");
      s = idle(); s.memread = 1; s.wen = 1; s.wsel = 5'd4; s.rsel2 = 5'd4;
      step(s, exc(5'b00000, 4'b0000, 0, 32'h0, 1, 0, 0), "halted_luse");
      s = idle(); s.nrst = 0;
      step(s, exc(5'b00000, 4'b0000, 0, 32'h0, 0, 0, 0), "halt_rst");
      s = idle();
      step(s, ex(5'b11111, 4'b0000, 0, 32'h0, 0), "halt_released");

      // stall counter saturation
      s = idle(); s.memread = 1; s.wen = 1; s.wsel = 5'd9; s.rsel1 = 5'd9;
      for (int i = 0; i < (1 << CNT_W) + 5; i++)
         drive(s);
      s = idle();
      step(s, exc(5'b11111, 4'b0000, 0, 32'h0, 0, 16'hFFFF, 0), "stall_sat");

      repeat (3) @(posedge CLK);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter SHALL be: CNT_W, 16, width of stall and redirect performance counters.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 nRST  in  1  asynchronous active-low reset.
REQ-005 ihit  in  1  instruction fetch complete this cycle.
REQ-006 dhit  in  1  data access complete this cycle.
REQ-007 mem_dreq  in  1  MEM-stage instruction is a load or store.
REQ-008 mem_halt  in  1  halt instruction in MEM.
REQ-009 br_taken  in  1  taken branch/jump resolved in MEM.
REQ-010 br_target  in  32  redirect address for br_taken.
REQ-011 id_rsel1, id_rsel2  in  5 each  ID-stage source registers.
REQ-012 ex_wsel  in  5  EX-stage destination register.
REQ-013 ex_wen, ex_memread  in  1 each  EX-stage writes register / is a load.
REQ-014 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables.
REQ-015 ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble into the stage register.
REQ-016 pc_redirect  out  1  PC loads redirect_addr this cycle.
REQ-017 redirect_addr  out  32  redirect target.
REQ-018 halted  out  1  pipeline halted, sticky.
REQ-019 stall_cnt, redir_cnt  out  CNT_W each  performance counters.

Function
REQ-020 The FSM SHALL have states RUN, FPEND (redirect pending on outstanding fetch), and HALT; all control outputs SHALL be combinational from state and inputs.
REQ-021 Definitions: dstall = mem_dreq & ~dhit; luse = ex_memread & ex_wen & (ex_wsel != 0) & (ex_wsel == id_rsel1 | ex_wsel == id_rsel2).
REQ-022 Default (no condition below active, RUN): all enables 1, all flushes 0, pc_redirect 0.
REQ-023 Per-cycle priority in RUN/FPEND SHALL be: mem_halt > dstall > br_taken > FPEND completion > luse > ~ihit.
REQ-024 mem_halt: all enables 0, all flushes 0; next state HALT.
REQ-025 HALT: all enables 0, flushes 0, halted = 1; exits only on reset.
REQ-026 dstall: pc_en, ifid_en, idex_en, exmem_en = 0; memwb_flush = 1; state unchanged; target latch unchanged.
REQ-027 br_taken with ihit (RUN): pc_en = 1, pc_redirect = 1, redirect_addr = br_target, ifid_flush = idex_flush = exmem_flush = 1; stay RUN.
REQ-028 br_taken with ~ihit (RUN): pc_en = 0, ifid_flush = idex_flush = exmem_flush = 1, br_target latched into the target register; next FPEND.
REQ-029 FPEND, ~ihit: pc_en = 0, ifid_flush = 1, other stages enabled.
REQ-030 FPEND, ihit: pc_en = 1, pc_redirect = 1, redirect_addr = latched target, ifid_flush = 1; next RUN.
REQ-031 br_taken in FPEND SHALL overwrite the latched target and apply REQ-027/028 rules.
REQ-032 luse: pc_en = 0, ifid_en = 0, idex_flush = 1, exmem_en = memwb_en = 1 (exactly one bubble per hazard).
REQ-033 ~ihit (RUN, nothing higher): pc_en = 0, ifid_flush = 1, others enabled.
REQ-034 Whenever pc_redirect = 0, redirect_addr SHALL equal the latched target register.
REQ-035 stall_cnt SHALL increment each cycle with pc_en = 0 and state != HALT and mem_halt = 0; it saturates at all-ones.
REQ-036 redir_cnt SHALL increment each cycle pc_redirect = 1; it saturates at all-ones.

Reset
REQ-037 While nRST = 0: state RUN, target register 0, counters 0, halted 0, all enables and flushes 0, pc_redirect 0, redirect_addr 0.
REQ-038 Reset asserted mid-FPEND or mid-dstall SHALL discard pending redirect; first cycle after release follows RUN rules.

Verification
REQ-039 Load r3 in EX, ID reads r3, ihit=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1; stall_cnt=1.
REQ-040 Same with ex_wsel=0 -> no stall, all enables 1.
REQ-041 mem_dreq=1, dhit=0 for 3 cycles then 1 -> 3 cycles freeze with memwb_flush=1, then normal; stall_cnt=3.
REQ-042 br_taken, br_target=0x00000040, ihit=0 for 2 cycles then 1 -> FPEND; on ihit cycle pc_redirect=1, redirect_addr=0x40, ifid_flush=1; redir_cnt=1.
REQ-043 mem_halt=1 simultaneous with dstall and luse -> all enables 0, halted=1 next cycle, remains through further inputs until nRST.
REQ-044 Saturation: force 2^CNT_W+5 load-use stalls -> stall_cnt holds 0xFFFF (CNT_W=16).
